// File: rtl/d_cache_controller.sv
// d_cache_controller: direct-mapped, write-through, no-write-allocate data cache
// for the mem stage. Read misses refill a whole line with a burst. Every store
// is sent to memory as a single-word write.
// Optional feature macro: D_CACHE_STATS_EN adds hitCount_o / missCount_o.
module d_cache_controller #(
  parameter int INDEX_WIDTH        = 5,
  parameter int BLOCK_OFFSET_WIDTH = 2,
  parameter int ADDR_WIDTH         = 16,
  parameter int DATA_WIDTH         = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  inValid_i,
  input  logic                  inMemAction_i,
  input  logic [ADDR_WIDTH-1:0] inAddr_i,
  input  logic [ADDR_WIDTH-1:0] inAddrNext_i,
  input  logic [DATA_WIDTH-1:0] inData_i,
  output logic                  outValid_o,
  output logic [DATA_WIDTH-1:0] outData_o,
  output logic                  memReqValid_o,
  input  logic                  memReqReady_i,
  output logic                  memReqWrite_o,
  output logic [ADDR_WIDTH-1:0] memReqAddr_o,
  output logic [DATA_WIDTH-1:0] memReqData_o,
  input  logic                  memRespValid_i,
  input  logic [DATA_WIDTH-1:0] memRespData_i
`ifdef D_CACHE_STATS_EN
  ,
  output logic [31:0]           hitCount_o,
  output logic [31:0]           missCount_o
`endif
);

  localparam int TAG_WIDTH = ADDR_WIDTH - INDEX_WIDTH - BLOCK_OFFSET_WIDTH;
  localparam int NUM_LINES = 1 << INDEX_WIDTH;
  localparam int WORDS     = 1 << BLOCK_OFFSET_WIDTH;

  // inMemAction_i encoding: 0 = READ, 1 = WRITE
  typedef enum logic [1:0] {
    IDLE,
    REFILL_REQ,
    REFILL,
    WRITE_REQ
  } state_e;

  state_e                        state_q, state_d;
  logic [BLOCK_OFFSET_WIDTH-1:0] refillCnt_q, refillCnt_d;
  logic                          memReqValid_q, memReqValid_d;
  logic                          memReqWrite_q, memReqWrite_d;
  logic [ADDR_WIDTH-1:0]         memReqAddr_q, memReqAddr_d;
  logic [DATA_WIDTH-1:0]         memReqData_q, memReqData_d;

  logic [NUM_LINES-1:0]          lineValid_q;
  logic [TAG_WIDTH-1:0]          lineTag_q  [NUM_LINES];
  logic [DATA_WIDTH-1:0]         lineData_q [NUM_LINES][WORDS];

  logic [TAG_WIDTH-1:0]          reqTag;
  logic [INDEX_WIDTH-1:0]        reqIndex;
  logic [BLOCK_OFFSET_WIDTH-1:0] reqOffset;
  logic [TAG_WIDTH-1:0]          fillTag;
  logic [INDEX_WIDTH-1:0]        fillIndex;
  logic [BLOCK_OFFSET_WIDTH-1:0] unusedFillOffset;
  logic                          unusedAddrNext;
  logic                          hit;
  logic                          fillWe;
  logic                          installLine;
  logic                          writeHitWe;

  assign {reqTag, reqIndex, reqOffset} = inAddr_i;
  // The refill target comes from the latched line base, so a flush of
  // inValid_i mid-refill still installs the line at the right place.
  assign {fillTag, fillIndex, unusedFillOffset} = memReqAddr_q;
  assign unusedAddrNext = ^inAddrNext_i;
  assign hit = lineValid_q[reqIndex] && (lineTag_q[reqIndex] == reqTag);

  assign memReqValid_o = memReqValid_q;
  assign memReqWrite_o = memReqWrite_q;
  assign memReqAddr_o  = memReqAddr_q;
  assign memReqData_o  = memReqData_q;

  // State, refill counter, memory request registers and line valid bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      refillCnt_q   <= '0;
      memReqValid_q <= 1'b0;
      memReqWrite_q <= 1'b0;
      memReqAddr_q  <= '0;
      memReqData_q  <= '0;
      lineValid_q   <= '0;
    end else begin
      state_q       <= state_d;
      refillCnt_q   <= refillCnt_d;
      memReqValid_q <= memReqValid_d;
      memReqWrite_q <= memReqWrite_d;
      memReqAddr_q  <= memReqAddr_d;
      memReqData_q  <= memReqData_d;
      if (installLine) begin
        lineValid_q[fillIndex] <= 1'b1;
      end
    end
  end

  // Tag and data storage: refill words, tag install and write-hit updates
  always_ff @(posedge clk) begin
    if (fillWe) begin
      lineData_q[fillIndex][refillCnt_q] <= memRespData_i;
    end
    if (installLine) begin
      lineTag_q[fillIndex] <= fillTag;
    end
    if (writeHitWe) begin
      lineData_q[reqIndex][reqOffset] <= inData_i;
    end
  end

  // Next-state, request register updates and the combinational response
  always_comb begin
    state_d       = state_q;
    refillCnt_d   = refillCnt_q;
    memReqValid_d = memReqValid_q;
    memReqWrite_d = memReqWrite_q;
    memReqAddr_d  = memReqAddr_q;
    memReqData_d  = memReqData_q;
    outValid_o    = 1'b0;
    outData_o     = '0;
    fillWe        = 1'b0;
    installLine   = 1'b0;
    writeHitWe    = 1'b0;
    case (state_q)
      IDLE: begin
        if (inValid_i) begin
          if (!inMemAction_i) begin
            if (hit) begin
              outValid_o = 1'b1;
              outData_o  = lineData_q[reqIndex][reqOffset];
            end else begin
              state_d       = REFILL_REQ;
              memReqValid_d = 1'b1;
              memReqWrite_d = 1'b0;
              memReqAddr_d  = {reqTag, reqIndex, {BLOCK_OFFSET_WIDTH{1'b0}}};
            end
          end else begin
            state_d       = WRITE_REQ;
            memReqValid_d = 1'b1;
            memReqWrite_d = 1'b1;
            memReqAddr_d  = inAddr_i;
            memReqData_d  = inData_i;
            writeHitWe    = hit;
          end
        end
      end
      REFILL_REQ: begin
        if (memReqReady_i) begin
          memReqValid_d = 1'b0;
          refillCnt_d   = '0;
          state_d       = REFILL;
        end
      end
      REFILL: begin
        if (memRespValid_i) begin
          fillWe      = 1'b1;
          refillCnt_d = refillCnt_q + 1'b1;
          if (refillCnt_q == '1) begin
            installLine = 1'b1;
            state_d     = IDLE;
          end
        end
      end
      WRITE_REQ: begin
        if (memReqReady_i) begin
          memReqValid_d = 1'b0;
          outValid_o    = inValid_i;
          state_d       = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef D_CACHE_STATS_EN
  logic [31:0] hitCount_q;
  logic [31:0] missCount_q;
  logic        retry_q;

  assign hitCount_o  = hitCount_q;
  assign missCount_o = missCount_q;

  // Hit/miss counters; retry_q marks a read already counted as a miss so
  // its post-refill hit is not counted again
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hitCount_q  <= '0;
      missCount_q <= '0;
      retry_q     <= 1'b0;
    end else begin
      if (state_q == IDLE && inValid_i) begin
        if (hit && !retry_q) begin
          hitCount_q <= hitCount_q + 32'd1;
        end
        if (!hit) begin
          missCount_q <= missCount_q + 32'd1;
        end
      end
      if (state_q == IDLE && inValid_i && !hit && !inMemAction_i) begin
        retry_q <= 1'b1;
      end else if (outValid_o || !inValid_i) begin
        retry_q <= 1'b0;
      end
    end
  end
`endif

endmodule

// File: doc/d_cache_controller.md
# d_cache_controller

Direct-mapped, write-through, no-write-allocate data cache. It is the responder for the mem stage: it consumes `d_cache_input_ifc` and answers on `cache_output_ifc`, whose `valid` gates the stage's done signal. Misses and all stores go to a simple request/response memory port.

## Interface
- `INDEX_WIDTH`, 5: log2 of the number of lines.
- `BLOCK_OFFSET_WIDTH`, 2: log2 of the words per line (4).
- `clk` input 1: the single clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `in` d_cache_input_ifc.in: `valid`, `mem_action` (READ/WRITE), `addr`, `addr_next`, `data`. `addr` is a word address of `ADDR_WIDTH` bits; `addr_next` is ignored.
- `out` cache_output_ifc.out: `valid`, `data` (`DATA_WIDTH`).
- `mem_req_valid` output 1: memory request.
- `mem_req_ready` input 1: memory accepts the request.
- `mem_req_write` output 1: 1 = single-word write, 0 = line-burst read.
- `mem_req_addr` output `ADDR_WIDTH`: word address. For a burst it is the line base (offset = 0).
- `mem_req_data` output `DATA_WIDTH`: write data.
- `mem_resp_valid` input 1: one burst word returned, in ascending offset order.
- `mem_resp_data` input `DATA_WIDTH`: returned word.
- `hit_count`, `miss_count` output 32: present only with `D_CACHE_STATS_EN`.

## Operation
- Address split: `tag = addr[ADDR_WIDTH-1 : INDEX_WIDTH+BLOCK_OFFSET_WIDTH]`, then index, then offset.
- Storage is flops: valid bit per line, tag per line, and words per line.
- Hit means the line is valid and its tag matches.
- States:
  - IDLE, the only state that evaluates requests.
  - REFILL_REQ
  - REFILL
  - WRITE_REQ
- IDLE, `in.valid` & READ & hit: `out.valid=1`, `out.data` = cached word, combinational, same cycle. No state change.
- IDLE, READ & miss: go to REFILL_REQ.
- REFILL_REQ:
  - Drive `mem_req_valid=1`, `mem_req_write=0`, line-base address.
  - On `mem_req_ready`, clear the counter and go to REFILL.
- REFILL:
  - Each `mem_resp_valid` writes the word at the counter offset into the line and increments the counter.
  - On the last word, set the tag and valid bit and return to IDLE. The pending read then hits.
- IDLE, `in.valid` & WRITE:
  - If hit, update the cached word in the first WRITE_REQ cycle.
  - Go to WRITE_REQ whether hit or miss. A miss does not allocate.
- WRITE_REQ:
  - Drive `mem_req_valid=1`, `mem_req_write=1`, `addr`, `in.data`.
  - On `mem_req_ready`: `out.valid=1` that cycle, return to IDLE.
- `in` is held stable by the pipeline until `out.valid`. A new request can be evaluated the cycle after `out.valid`.
- `in.valid` falling mid-refill (flush): the refill still completes and installs the line. No `out.valid` is produced.
- `in.valid` falling in WRITE_REQ: the request stays asserted until accepted, with address and data latched on IDLE exit. `out.valid` is suppressed.
- `mem_resp_valid` outside REFILL: ignored.
- Request outputs stay stable while `mem_req_valid & ~mem_req_ready`.

## Timing
- Reset (asynchronous, `rst_n=0`):
  - State goes to IDLE and the counter to 0.
  - All line valid bits clear; tags and data are don't-care.
  - `out.valid=0`, `out.data=0`, `mem_req_valid=0`, `mem_req_write=0`, `mem_req_addr=0`, `mem_req_data=0`, counters 0.
- Reset mid-refill or mid-write: the operation is abandoned. Late `mem_resp_valid` is ignored.
- Read hit: 0 cycles (combinational).
- Read miss, with ready latency R and response gap 0: `out.valid` comes 1 + R + 4 + 1 cycles after the request.
- Write: `out.valid` comes 1 + R cycles after the request. With R = 0, that is the cycle after it appears.
- Registered: `mem_req_*`, state, storage. Combinational: `out.valid`, `out.data`.

## Configuration
- `D_CACHE_STATS_EN` defined:
  - `hit_count` increments once per accepted request that hits in IDLE on its first evaluation cycle, reads and writes.
  - `miss_count` increments on the transition out of IDLE for a miss.
  - Both are 32-bit, wrap modulo 2^32, and reset to 0.
- Undefined: the ports and counters are absent. All other behaviour is identical.

## Test plan
- Reset, then READ `addr=0x040` with memory returning 0xA0..0xA3:
  - burst request at `mem_req_addr=0x040`;
  - `out.valid` with `data=0xA0` in the cycle after the 4th response.
  - Then READ `0x042` → same-cycle hit, `data=0xA2`.
- WRITE `0x041` data 0x55 after that fill:
  - `mem_req_write=1`, addr 0x041, data 0x55; `out.valid` on accept.
  - Then READ `0x041` → hit, 0x55.
- WRITE miss `0x300` data 0x77:
  - single-word write only, no burst.
  - A later READ `0x300` misses and issues a burst.
- Conflict: READ `0x040`, then READ `0x040 + (1<<7)`:
  - second read refills the same index.
  - Re-reading `0x040` misses again.
- `mem_req_ready` held low 5 cycles during REFILL_REQ and WRITE_REQ: request outputs stable, `out.valid` stays 0.
- `rst_n` low on the 2nd refill response: `out.valid=0`, the line is invalid afterwards, and trailing `mem_resp_valid` pulses are ignored.
- With `D_CACHE_STATS_EN`, the first test gives `hit_count=1`, `miss_count=1`.
